// File: rtl/maze_campaign_pkg.sv
// rtl/maze_campaign_pkg.sv - shared state type, coordinates and per-level wall maps
package maze_campaign_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WIN  = 2'd1,
    ST_FAIL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] START_X = 3'd0;
  localparam logic [2:0] START_Y = 3'd0;
  localparam logic [2:0] GOAL_X  = 3'd7;
  localparam logic [2:0] GOAL_Y  = 3'd7;

  localparam logic [63:0] FAIL_PATTERN = 64'h8142_2418_1824_4281;
  localparam logic [63:0] GOAL_BIT     = 64'h8000_0000_0000_0000;

  // Bit {y,x} set means a wall. Column x=0 and row y=7 stay open on every level.
  function automatic logic [63:0] level_walls(input logic [1:0] level);
    logic [63:0] walls;
    case (level)
      2'd0:    walls = 64'h0006_1650_5C04_7470;
      2'd1:    walls = 64'h003C_2042_5A24_1E00;
      2'd2:    walls = 64'h007E_0240_3E08_6A00;
      default: walls = 64'h0054_2A14_4A32_0C00;
    endcase
    return walls;
  endfunction

endpackage

// File: rtl/maze_campaign_if.sv
// rtl/maze_campaign_if.sv - arcade shell game port bundle
interface maze_campaign_if;
  logic [4:0]  btn_pulse;
  logic [15:0] sw;
  logic [15:0] led;
  logic [63:0] grid;
  logic        check_ok;
  logic [7:0]  score;

  modport master (
    output btn_pulse, sw,
    input  led, grid, check_ok, score
  );

  modport slave (
    input  btn_pulse, sw,
    output led, grid, check_ok, score
  );
endinterface

// File: rtl/maze_campaign_tick_divider.sv
// rtl/maze_campaign_tick_divider.sv - free-running divider with toggle and one-cycle tick
module maze_campaign_tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic toggle,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      toggle <= 1'b0;
    end else if (tick) begin
      count  <= '0;
      toggle <= ~toggle;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/maze_campaign.sv
// rtl/maze_campaign.sv - multi-level maze game with move budget and win/fail/done sequencing
module maze_campaign
  import maze_campaign_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int MOVE_LIMIT = 32,
  parameter int BLINK_DIV  = 4_166_667,
  parameter int WIN_HOLD   = 50_000_000
) (
  input logic            clk,
  input logic            rst,
  maze_campaign_if.slave bus
);
  localparam int LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int HOLD_W = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
  localparam logic [5:0]        LIMIT      = 6'(MOVE_LIMIT);
  localparam logic [LVL_W-1:0]  LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W:0]    LEVEL_CNT  = (LVL_W + 1)'(NUM_LEVELS);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(WIN_HOLD - 1);

  state_t            state, state_n;
  logic [LVL_W-1:0]  level, level_n;
  logic [2:0]        x, y, x_n, y_n;
  logic [5:0]        moves_left, moves_left_n;
  logic [7:0]        score, score_n;
  logic [HOLD_W-1:0] hold, hold_n;

  logic              blink;
  logic              unused_tick;
  logic              unused_sw;
  logic [63:0]       walls;
  logic [63:0]       player;
  logic [2:0]        tx, ty;
  logic              in_range;
  logic              move_ok;
  logic              practice;
  logic [LVL_W-1:0]  sw_level;
  logic [LVL_W-1:0]  sel_level;

  maze_campaign_tick_divider #(.DIV(BLINK_DIV)) u_blink (
    .clk    (clk),
    .rst    (rst),
    .toggle (blink),
    .tick   (unused_tick)
  );

  assign unused_sw = ^bus.sw[14:LVL_W];
  assign practice  = bus.sw[15];
  assign sw_level  = bus.sw[LVL_W-1:0];
  assign sel_level = ({1'b0, sw_level} >= LEVEL_CNT) ? '0 : sw_level;
  assign walls     = level_walls(2'(level));
  assign player    = 64'd1 << {y, x};

  // Priority up > down > left > right; target is only meaningful when in_range.
  always_comb begin
    tx       = x;
    ty       = y;
    in_range = 1'b0;
    if (bus.btn_pulse[0]) begin
      in_range = (y != 3'd0);
      ty       = y - 3'd1;
    end else if (bus.btn_pulse[1]) begin
      in_range = (y != 3'd7);
      ty       = y + 3'd1;
    end else if (bus.btn_pulse[2]) begin
      in_range = (x != 3'd0);
      tx       = x - 3'd1;
    end else if (bus.btn_pulse[3]) begin
      in_range = (x != 3'd7);
      tx       = x + 3'd1;
    end
  end

  assign move_ok = (state == ST_PLAY) && in_range && !walls[{ty, tx}];

  always_comb begin
    state_n      = state;
    level_n      = level;
    x_n          = x;
    y_n          = y;
    moves_left_n = moves_left;
    score_n      = score;
    hold_n       = '0;
    if (bus.btn_pulse[4]) begin
      state_n      = ST_PLAY;
      level_n      = sel_level;
      x_n          = START_X;
      y_n          = START_Y;
      moves_left_n = LIMIT;
      score_n      = '0;
    end else begin
      case (state)
        ST_PLAY: begin
          if (move_ok) begin
            x_n     = tx;
            y_n     = ty;
            score_n = (score == 8'hFF) ? score : score + 1'b1;
            if (!practice) moves_left_n = moves_left - 1'b1;
            // Reaching the goal wins even when it spends the last move.
            if (tx == GOAL_X && ty == GOAL_Y) state_n = ST_WIN;
            else if (!practice && moves_left == 6'd1) state_n = ST_FAIL;
          end
        end
        ST_WIN: begin
          if (hold == HOLD_LAST) begin
            if (level == LAST_LEVEL) begin
              state_n = ST_DONE;
            end else begin
              state_n      = ST_PLAY;
              level_n      = level + 1'b1;
              x_n          = START_X;
              y_n          = START_Y;
              moves_left_n = LIMIT;
            end
          end else begin
            hold_n = hold + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PLAY;
      level      <= '0;
      x          <= START_X;
      y          <= START_Y;
      moves_left <= LIMIT;
      score      <= '0;
      hold       <= '0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      x          <= x_n;
      y          <= y_n;
      moves_left <= moves_left_n;
      score      <= score_n;
      hold       <= hold_n;
    end
  end

  always_comb begin
    case (state)
      ST_PLAY: bus.grid = walls | GOAL_BIT | (blink ? player : 64'd0);
      ST_WIN:  bus.grid = blink ? {64{1'b1}} : (walls | player);
      ST_FAIL: bus.grid = blink ? FAIL_PATTERN : 64'd0;
      default: bus.grid = {64{1'b1}};
    endcase
  end

  assign bus.led      = {6'd0, moves_left, 2'(level), state == ST_FAIL,
                         (state == ST_WIN) || (state == ST_DONE)};
  assign bus.check_ok = (state == ST_DONE);
  assign bus.score    = score;
endmodule
